// File: rtl/expr_vec_pkg.sv
// ============================================================================
// Module   : expr_vec_pkg
// Purpose  : Shared constants, field-layout helpers and the FSM state type for
//            the expression result vector unpacker.
// Contents : VEC_W / NUM_FIELDS / GROUP_W, per-k width and signedness tables,
//            field_width(idx), field_signed(idx), state_t {IDLE, STREAM}.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package expr_vec_pkg;

  localparam int VEC_W            = 90;
  localparam int NUM_FIELDS       = 18;
  localparam int GROUP_W          = 30;
  localparam int FIELDS_PER_GROUP = 6;

  // Field widths for k = 0..5, k = 0 in the top three bits: 4,5,6,4,5,6.
  localparam logic [17:0] FIELD_W_TAB = {3'd4, 3'd5, 3'd6, 3'd4, 3'd5, 3'd6};

  // Signedness per k, bit k set means signed (k = 3..5).
  localparam logic [5:0] FIELD_SIGNED_TAB = 6'b111000;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  function automatic logic [2:0] field_width(input logic [4:0] idx);
    logic [4:0] k;
    k = idx % 5'd6;
    return FIELD_W_TAB[(5 - int'(k)) * 3 +: 3];
  endfunction

  function automatic logic field_signed(input logic [4:0] idx);
    logic [4:0] k;
    k = idx % 5'd6;
    return FIELD_SIGNED_TAB[k[2:0]];
  endfunction

endpackage

`default_nettype wire

// File: rtl/expr_field_extend.sv
// ============================================================================
// Module   : expr_field_extend
// Purpose  : Widen one left-aligned field (4..6 bits) to OUT_W bits, sign- or
//            zero-extending according to the field's signedness.
// Ports    : top_bits  - top 6 bits of the shift register, field left-aligned
//            width     - field width in bits (4..6)
//            is_signed - 1: sign-extend, 0: zero-extend
//            data      - extended OUT_W-bit value
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module expr_field_extend #(
  parameter int OUT_W = 8
) (
  input  logic [5:0]       top_bits,
  input  logic [2:0]       width,
  input  logic             is_signed,
  output logic [OUT_W-1:0] data
);

  logic [5:0]       w_field;
  logic             w_fill;
  logic [OUT_W-1:0] w_mask;

  // Right-align the field; its MSB is always top_bits[5].
  assign w_field = top_bits >> (3'd6 - width);
  assign w_fill  = is_signed & top_bits[5];
  // Ones in the field's bit positions, zeros above.
  assign w_mask  = ~({OUT_W{1'b1}} << width);
  assign data    = (OUT_W'(w_field) & w_mask) | ({OUT_W{w_fill}} & ~w_mask);

endmodule

`default_nettype wire

// File: rtl/expr_vec_unpacker.sv
// ============================================================================
// Module   : expr_vec_unpacker
// Purpose  : Accept a 90-bit packed result vector {y0..y17} and stream its 18
//            fields out one per handshake, each extended to OUT_W bits.
// Ports    : clk, rst_n (async active-low)
//            in_valid / in_ready / in_vec          - vector input handshake
//            out_valid / out_ready / out_idx /
//            out_data / out_last                   - field output handshake
//            vec_count                             - completed vectors (wraps)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module expr_vec_unpacker #(
  parameter int VEC_W      = 90,
  parameter int NUM_FIELDS = 18,
  parameter int OUT_W      = 8,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [VEC_W-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       out_idx,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last,
  output logic [CNT_W-1:0] vec_count
);

  import expr_vec_pkg::*;

  state_t           r_state;
  state_t           w_next;
  logic [VEC_W-1:0] r_shift;
  logic [4:0]       r_idx;
  logic [CNT_W-1:0] r_count;

  logic             w_hs;
  logic             w_last;
  logic             w_load;
  logic [2:0]       w_width;
  logic             w_signed;
  logic [OUT_W-1:0] w_ext;

  assign out_valid = (r_state == STREAM);
  assign w_last    = out_valid & (r_idx == 5'(NUM_FIELDS - 1));
  assign w_hs      = out_valid & out_ready;
  // Accepting during the final field handshake keeps back-to-back vectors
  // bubble-free; this makes in_ready combinational from out_ready.
  assign in_ready  = (r_state == IDLE) | (w_hs & w_last);
  assign w_load    = in_valid & in_ready;

  assign w_width   = field_width(r_idx);
  assign w_signed  = field_signed(r_idx);

  expr_field_extend #(
    .OUT_W (OUT_W)
  ) u_extend (
    .top_bits  (r_shift[VEC_W-1 -: 6]),
    .width     (w_width),
    .is_signed (w_signed),
    .data      (w_ext)
  );

  assign out_idx   = r_idx;
  assign out_last  = w_last;
  assign out_data  = out_valid ? w_ext : '0;
  assign vec_count = r_count;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_load) w_next = STREAM;
      STREAM:  if (w_hs & w_last) w_next = in_valid ? STREAM : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_idx   <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_shift <= in_vec;
        r_idx   <= '0;
      end else if (w_hs) begin
        r_shift <= r_shift << w_width;
        // Park at 0 after the last field so out_idx never leaves 0..17.
        r_idx   <= w_last ? 5'd0 : r_idx + 5'd1;
      end
      if (w_hs & w_last) r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire
